// File: rtl/multicycle_control_fsm_if.sv
// Shared memory port handshake between the sequencer and the memory.
// The sequencer holds mem_req/mem_we steady until the memory returns mem_ready.
interface multicycle_control_fsm_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the MIPS datapath. It steps each instruction through
// fetch/decode/execute/memory/writeback. It drives the per-cycle datapath strobes
// and shares one memory port between instruction fetch and data access.
module multicycle_control_fsm #(
   parameter int unsigned CNT_W = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [5:0]                 Op_code,
   input  logic                       Zero,
   multicycle_control_fsm_if.master   mem,
   output logic                       ir_write,
   output logic                       pc_write,
   output logic [1:0]                 pc_src,
   output logic [1:0]                 alu_src_b,
   output logic                       reg_write,
   output logic                       reg_dst,
   output logic                       mem_to_reg,
   output logic [3:0]                 state,
   output logic                       illegal,
   output logic [CNT_W-1:0]           instr_count
);

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StExecR  = 4'd2,
      StWbR    = 4'd3,
      StExecI  = 4'd4,
      StWbI    = 4'd5,
      StAddr   = 4'd6,
      StMemRd  = 4'd7,
      StMemWb  = 4'd8,
      StMemWr  = 4'd9,
      StBranch = 4'd10,
      StJump   = 4'd11,
      StHalt   = 4'd15
   } state_e;

   state_e           state_q, state_d;
   logic             illegal_q;
   logic [CNT_W-1:0] count_q;
   logic             retire;

   assign state       = state_q;
   assign illegal     = illegal_q;
   assign instr_count = count_q;

   // Next-state decode and strobes from registered state; reset forces all strobes low.
   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_b  = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;

      case (state_q)
         StFetch: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end
         end
         StDecode: begin
            alu_src_b = 2'b11;
            case (Op_code)
               OpRtype:                        state_d = StExecR;
               OpAddi, OpSlti, OpAndi, OpOri:  state_d = StExecI;
               OpLw, OpSw:                     state_d = StAddr;
               OpBeq:                          state_d = StBranch;
               OpJ:                            state_d = StJump;
               default:                        state_d = StHalt;
            endcase
         end
         StExecR: begin
            state_d = StWbR;
         end
         StWbR: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
            state_d   = StFetch;
         end
         StExecI: begin
            alu_src_b = 2'b10;
            state_d   = StWbI;
         end
         StWbI: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = StFetch;
         end
         StAddr: begin
            alu_src_b = 2'b10;
            state_d   = (Op_code == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ready) begin
               state_d = StMemWb;
            end
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = StFetch;
         end
         StMemWr: begin
            mem.mem_req = 1'b1;
            mem.mem_we  = 1'b1;
            if (mem.mem_ready) begin
               retire  = 1'b1;
               state_d = StFetch;
            end
         end
         StBranch: begin
            pc_src   = 2'b01;
            pc_write = Zero;
            retire   = 1'b1;
            state_d  = StFetch;
         end
         StJump: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         // Unused encodings recover to fetch.
         default: begin
            state_d = StFetch;
         end
      endcase

      if (reset) begin
         mem.mem_req = 1'b0;
         mem.mem_we  = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = 2'b00;
         alu_src_b  = 2'b00;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         retire     = 1'b0;
      end
   end

   // State register, sticky illegal flag and retired-instruction counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == StHalt) begin
            illegal_q <= 1'b1;
         end
         if (retire) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

endmodule
